// File: rtl/game_pkg.sv
// Constants and types shared by the game display path.
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        FIN   = 2'd3
    } render_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major sprite offset counter: cx sweeps 0..W-1, then cy steps; last flags the final pixel.
module sprite_scan_counter #(
    parameter int W = 4,
    parameter int H = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       en,
    output logic [2:0] cx,
    output logic [2:0] cy,
    output logic       last
);

    localparam logic [2:0] CX_LAST = 3'(W - 1);
    localparam logic [2:0] CY_LAST = 3'(H - 1);

    assign last = (cx == CX_LAST) && (cy == CY_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx <= 3'd0;
            cy <= 3'd0;
        end else if (clear) begin
            cx <= 3'd0;
            cy <= 3'd0;
        end else if (en) begin
            if (cx == CX_LAST) begin
                cx <= 3'd0;
                cy <= (cy == CY_LAST) ? 3'd0 : cy + 3'd1;
            end else begin
                cx <= cx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/player_sprite_renderer.sv
// Per-frame sprite redraw: erase at the last drawn position, draw at the new one, one pixel per clock.
//   state | meaning
//   IDLE  | waiting for frame_tick (ignored while busy is still high)
//   ERASE | scanning old sprite in BG_COLOUR
//   DRAW  | scanning new sprite in latched colour
//   FIN   | one cycle, done pulses on the next cycle
module player_sprite_renderer
    import game_pkg::*;
#(
    parameter int         SPR_W     = 4,
    parameter int         SPR_H     = 4,
    parameter int         X_MAX     = SCREEN_W - 1,
    parameter int         Y_MAX     = SCREEN_H - 1,
    parameter logic [2:0] FG_COLOUR = WHITE,
    parameter logic [2:0] BG_COLOUR = BLACK
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    input  logic       alive,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    render_state_t state, state_next;

    logic [7:0] new_x, old_x, base_x;
    logic [6:0] new_y, old_y, base_y;
    logic [2:0] new_col, old_col, pix_col, tick_col;
    logic       has_drawn;
    logic       latch, commit, pix_gen, scan_clear, scan_en;
    logic [2:0] cx, cy;
    logic       scan_last;
    logic [8:0] px;
    logic [7:0] py;
    logic       in_range;

    sprite_scan_counter #(.W(SPR_W), .H(SPR_H)) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (scan_clear),
        .en      (scan_en),
        .cx      (cx),
        .cy      (cy),
        .last    (scan_last)
    );

    assign tick_col = alive ? FG_COLOUR : BG_COLOUR;

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        commit     = 1'b0;
        pix_gen    = 1'b0;
        scan_clear = 1'b0;
        scan_en    = 1'b0;
        case (state)
            IDLE: begin
                scan_clear = 1'b1;
                // busy still covers the done cycle, so a tick there is dropped too
                if (frame_tick && !busy) begin
                    latch = 1'b1;
                    if (has_drawn && pos_x == old_x && pos_y == old_y && tick_col == old_col)
                        state_next = FIN;
                    else if (!has_drawn)
                        state_next = DRAW;
                    else
                        state_next = ERASE;
                end
            end
            ERASE: begin
                pix_gen = 1'b1;
                scan_en = 1'b1;
                if (scan_last) begin
                    scan_clear = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                pix_gen = 1'b1;
                scan_en = 1'b1;
                if (scan_last) begin
                    commit     = 1'b1;
                    state_next = FIN;
                end
            end
            FIN: begin
                scan_clear = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign base_x  = (state == ERASE) ? old_x : new_x;
    assign base_y  = (state == ERASE) ? old_y : new_y;
    assign pix_col = (state == ERASE) ? BG_COLOUR : new_col;
    // widened sums so an off-screen pixel is clipped rather than wrapped
    assign px       = {1'b0, base_x} + {6'd0, cx};
    assign py       = {1'b0, base_y} + {5'd0, cy};
    assign in_range = (px <= 9'(X_MAX)) && (py <= 8'(Y_MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            new_x      <= 8'd0;
            new_y      <= 7'd0;
            new_col    <= BG_COLOUR;
            old_x      <= 8'd0;
            old_y      <= 7'd0;
            old_col    <= 3'd0;
            has_drawn  <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state    <= state_next;
            vga_plot <= pix_gen && in_range;
            done     <= (state == FIN);
            busy     <= (state_next != IDLE) || (state != IDLE);
            if (latch) begin
                new_x   <= pos_x;
                new_y   <= pos_y;
                new_col <= tick_col;
            end
            if (commit) begin
                old_x     <= new_x;
                old_y     <= new_y;
                old_col   <= new_col;
                has_drawn <= 1'b1;
            end
            if (pix_gen && in_range) begin
                vga_x      <= px[7:0];
                vga_y      <= py[6:0];
                vga_colour <= pix_col;
            end
        end
    end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Randomized and directed bench for player_sprite_renderer against a cycle-expectation queue model.
module tb_player_sprite_renderer;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int XM = 159;
    localparam int YM = 119;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] pos_x = 8'd0;
    logic [6:0] pos_y = 7'd0;
    logic       alive = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    player_sprite_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .alive      (alive),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of what each upcoming cycle must show, built when a tick is accepted.
    typedef struct {
        bit busy;
        bit done;
        bit plot;
        int x;
        int y;
        int col;
    } exp_t;

    exp_t q[$];
    bit   m_drawn = 0;
    int   m_ox = 0, m_oy = 0, m_oc = 0;
    int   last_x = 0, last_y = 0, last_c = 0;

    function automatic exp_t mk(bit b, bit d, bit p, int x, int y, int c);
        exp_t e;
        e.busy = b; e.done = d; e.plot = p; e.x = x; e.y = y; e.col = c;
        return e;
    endfunction

    function automatic void push_sprite(int bx, int by, int c);
        for (int r = 0; r < SH; r++)
            for (int k = 0; k < SW; k++)
                q.push_back(mk(1, 0, (bx + k <= XM) && (by + r <= YM), bx + k, by + r, c));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   nc;
        if (!reset_n) begin
            q.delete();
            m_drawn = 0;
            m_ox = 0; m_oy = 0; m_oc = 0;
            last_x = 0; last_y = 0; last_c = 0;
        end
        if (q.size() > 0) e = q.pop_front();
        else e = mk(0, 0, 0, 0, 0, 0);
        if (e.plot) begin
            last_x = e.x; last_y = e.y; last_c = e.col;
        end
        chk("plot", int'(vga_plot), int'(e.plot));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("x", int'(vga_x), last_x);
        chk("y", int'(vga_y), last_y);
        chk("colour", int'(vga_colour), last_c);
        if (reset_n && frame_tick && q.size() == 0 && !e.busy) begin
            nc = alive ? 7 : 0;
            q.push_back(mk(1, 0, 0, 0, 0, 0));
            if (!(m_drawn && int'(pos_x) == m_ox && int'(pos_y) == m_oy && nc == m_oc)) begin
                if (m_drawn) push_sprite(m_ox, m_oy, 0);
                push_sprite(int'(pos_x), int'(pos_y), nc);
                m_ox = int'(pos_x); m_oy = int'(pos_y); m_oc = nc; m_drawn = 1;
            end
            q.push_back(mk(1, 1, 0, 0, 0, 0));
        end
    end

    // Issue one tick (optionally held a second cycle) and report what the DUT emitted until done.
    task automatic run_tick(input int x, input int y, input bit al, input bit extra,
                            output int nplots, output int done_off, output int busy_cnt,
                            output int fx, output int fy, output int lx, output int ly,
                            output int lc);
        nplots = 0; done_off = -1; busy_cnt = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; lc = -1;
        @(posedge clk); #1;
        pos_x = 8'(x); pos_y = 7'(y); alive = al; frame_tick = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            frame_tick = (k == 1) ? extra : 1'b0;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (vga_plot) begin
                if (nplots == 0) begin fx = int'(vga_x); fy = int'(vga_y); end
                lx = int'(vga_x); ly = int'(vga_y); lc = int'(vga_colour);
                nplots++;
            end
            if (done) begin done_off = k; break; end
        end
        chk("done_seen", int'(done_off > 0), 1);
    endtask

    int np, dof, bc, fx, fy, lx, ly, lc, extra_done;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_colour", int'(vga_colour), 0);
        reset_n = 1'b1;

        run_tick(78, 100, 1, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t1_plots", np, 16);
        chk("t1_done", dof, 18);
        chk("t1_first_x", fx, 78);
        chk("t1_first_y", fy, 100);
        chk("t1_last_x", lx, 81);
        chk("t1_last_y", ly, 103);
        chk("t1_colour", lc, 7);

        run_tick(79, 100, 1, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t2_plots", np, 32);
        chk("t2_done", dof, 34);
        chk("t2_busy", bc, 34);
        chk("t2_first_x", fx, 78);
        chk("t2_last_x", lx, 82);

        run_tick(79, 100, 1, 1, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t3_plots", np, 0);
        chk("t3_done", dof, 2);
        extra_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        chk("t3_no_second_done", extra_done, 0);

        run_tick(79, 100, 0, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t4_plots", np, 32);
        chk("t4_colour", lc, 0);
        run_tick(79, 100, 0, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t4_skip_done", dof, 2);

        run_tick(158, 118, 1, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t5a_plots", np, 20);
        chk("t5a_done", dof, 34);
        run_tick(158, 118, 0, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t5b_plots", np, 8);
        chk("t5b_done", dof, 34);
        chk("t5b_last_x", lx, 159);

        // reset during draw pixel 5 of an erase+draw redraw
        @(posedge clk); #1;
        pos_x = 8'd10; pos_y = 7'd10; alive = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (21) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_plot", int'(vga_plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_tick(20, 20, 1, 0, np, dof, bc, fx, fy, lx, ly, lc);
        chk("t6_no_erase_done", dof, 18);
        chk("t6_plots", np, 16);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            frame_tick = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin pos_x = 8'($urandom_range(150, 159)); pos_y = 7'($urandom_range(110, 119)); end
                    1: begin pos_x = 8'($urandom_range(0, 255)); pos_y = 7'($urandom_range(0, 127)); end
                    default: begin pos_x = 8'($urandom_range(0, 159)); pos_y = 7'($urandom_range(0, 119)); end
                endcase
                alive = ($urandom_range(0, 3) != 0);
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
        end
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (50) @(posedge clk);
        chk("end_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
